// File: rtl/reset_synchronizer_pkg.sv
// -----------------------------------------------------------------------------
// reset_synchronizer_pkg
//   Constants shared by the reset bridge: the legal range of the synchronizer
//   chain length. Kept here so any wrapper that picks a chain length per clock
//   domain can check it against the same bounds the bridge enforces.
// -----------------------------------------------------------------------------
package reset_synchronizer_pkg;

  // Fewer than two flops leaves no stage to resolve a metastable first flop.
  // Beyond eight the extra latency buys nothing measurable in MTBF.
  localparam int STAGES_MIN = 2;
  localparam int STAGES_MAX = 8;

endpackage : reset_synchronizer_pkg

// File: rtl/reset_synchronizer.sv
// -----------------------------------------------------------------------------
// reset_synchronizer
//   Reset bridge for one clock domain. The raw reset asserts the domain reset
//   immediately, with no clock needed. Release reaches the domain only after
//   STAGES rising edges of clk_sync. Instantiate once at the top of each clock
//   domain and feed its output to every async reset in that domain.
//
// Parameters
//   STAGES         synchronizer length (2..8); equals the release latency in
//                  clk_sync rising edges
//
// Ports
//   clk_sync       in   domain clock
//   reset_async_n  in   raw reset, active-low, asynchronous to clk_sync
//   reset_sync_n   out  domain reset, active-low, driven straight from the
//                       last chain flop
// -----------------------------------------------------------------------------
module reset_synchronizer
  import reset_synchronizer_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk_sync,
  input  logic reset_async_n,
  output logic reset_sync_n
);

  // Reject illegal chain lengths while the design is being elaborated.
  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_stages_check
    $error("reset_synchronizer: STAGES=%0d outside legal range %0d..%0d",
           STAGES, STAGES_MIN, STAGES_MAX);
  end

  // Chain flops: sync_q[0] may go metastable when release lands near an edge.
  // The later stages give it time to resolve. Keep the flops adjacent and
  // out of any retiming or duplication.
  (* ASYNC_REG = "TRUE" *) (* keep = "true" *)
  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift a constant 1 in at the bottom of the chain.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], 1'b1};
  end

  // NOTE: every chain flop takes the raw reset asynchronously. A low pulse
  // of any width clears the whole chain at once, and the release count
  // starts again from zero.
  always_ff @(posedge clk_sync or negedge reset_async_n) begin
    if (!reset_async_n) begin
      sync_q <= '0;
    end else begin
      // NOTE: non-blocking, so each stage samples its neighbour's old value.
      sync_q <= sync_d;
    end
  end

  // The output comes directly from a flop. Any gate here could glitch the
  // reset of an entire domain.
  assign reset_sync_n = sync_q[STAGES-1];

endmodule : reset_synchronizer

// File: tb/tb_reset_synchronizer.sv
// -----------------------------------------------------------------------------
// tb_reset_synchronizer
//   Directed bench for the reset bridge. It drives two instances, one with
//   STAGES=2 and one with STAGES=3, from a shared clock. The clock starts
//   high with a period of 10, so rising edges fall at 10, 20, 30 and so on.
//   Each time the stimulus causes an output transition, it first pushes the
//   expected (time, value) pair onto a per-instance queue. A monitor pops
//   the queue on every output change and compares the pair. Directed
//   mid-cycle samples cover the stretches where the output must not move.
// -----------------------------------------------------------------------------
module tb_reset_synchronizer;

  typedef struct {
    longint t;
    logic   v;
  } exp_t;

  logic clk_sync;
  logic rst2_async_n;
  logic rst3_async_n;
  logic rst2_sync_n;
  logic rst3_sync_n;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  bit   mon_en = 1'b0;
  exp_t q2[$];
  exp_t q3[$];

  reset_synchronizer #(.STAGES(2)) dut2 (
    .clk_sync      (clk_sync),
    .reset_async_n (rst2_async_n),
    .reset_sync_n  (rst2_sync_n)
  );

  reset_synchronizer #(.STAGES(3)) dut3 (
    .clk_sync      (clk_sync),
    .reset_async_n (rst3_async_n),
    .reset_sync_n  (rst3_sync_n)
  );

  initial begin
    clk_sync = 1'b1;
    forever #5 clk_sync = ~clk_sync;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic at(input longint t);
    if (t > $time) #(t - $time);
  endtask

  // Every output change must have been announced by the stimulus beforehand.
  always @(rst2_sync_n) begin
    if (mon_en) begin
      check("s2_change_expected", 64'(q2.size() > 0), 64'd1);
      if (q2.size() > 0) begin
        exp_t e;
        e = q2.pop_front();
        check("s2_change_time",  64'($time),    64'(e.t));
        check("s2_change_value", 64'(rst2_sync_n), 64'(e.v));
      end
    end
  end

  always @(rst3_sync_n) begin
    if (mon_en) begin
      check("s3_change_expected", 64'(q3.size() > 0), 64'd1);
      if (q3.size() > 0) begin
        exp_t e;
        e = q3.pop_front();
        check("s3_change_time",  64'($time),    64'(e.t));
        check("s3_change_value", 64'(rst3_sync_n), 64'(e.v));
      end
    end
  end

  initial begin
    rst2_async_n = 1'b0;
    rst3_async_n = 1'b0;

    // 1. Power-up reset, released at t=1. The output rises on the 2nd edge (t=20).
    at(1);
    check("s2_reset_state", 64'(rst2_sync_n), 64'd0);
    check("s3_reset_state", 64'(rst3_sync_n), 64'd0);
    mon_en = 1'b1;
    q2.push_back('{20, 1'b1});
    rst2_async_n = 1'b1;
    at(15); check("s2_after_1st_edge", 64'(rst2_sync_n), 64'd0);
    at(19); check("s2_before_2nd_edge", 64'(rst2_sync_n), 64'd0);
    at(21); check("s2_released", 64'(rst2_sync_n), 64'd1);

    // 2. Short assertion 35..38 between edges. The output falls at once and rises at 50.
    at(34); check("s2_steady_high", 64'(rst2_sync_n), 64'd1);
    at(35);
    q2.push_back('{35, 1'b0});
    rst2_async_n = 1'b0;
    at(36); check("s2_async_assert", 64'(rst2_sync_n), 64'd0);
    at(38);
    q2.push_back('{50, 1'b1});
    rst2_async_n = 1'b1;
    at(41); check("s2_one_edge_after", 64'(rst2_sync_n), 64'd0);
    at(51); check("s2_rereleased", 64'(rst2_sync_n), 64'd1);

    // 3. Two glitches, 62-64 and 66-68. The count restarts from 68, so the output rises at 80.
    at(62);
    q2.push_back('{62, 1'b0});
    rst2_async_n = 1'b0;
    at(63); check("s2_glitch_assert", 64'(rst2_sync_n), 64'd0);
    at(64); rst2_async_n = 1'b1;
    at(66); rst2_async_n = 1'b0;
    at(68);
    q2.push_back('{80, 1'b1});
    rst2_async_n = 1'b1;
    at(71); check("s2_no_rise_at_70", 64'(rst2_sync_n), 64'd0);
    at(81); check("s2_rise_at_80", 64'(rst2_sync_n), 64'd1);

    // 4. Held low from 90. The output stays low across every later edge.
    at(90);
    q2.push_back('{90, 1'b0});
    rst2_async_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      at(91 + 10 * k);
      check("s2_held_low", 64'(rst2_sync_n), 64'd0);
    end

    // 5. STAGES=3, released at 121, just after the edge at 120. It rises on the 3rd edge (150).
    check("s3_still_reset", 64'(rst3_sync_n), 64'd0);
    at(121);
    q3.push_back('{150, 1'b1});
    rst3_async_n = 1'b1;
    at(141); check("s3_two_edges", 64'(rst3_sync_n), 64'd0);
    at(149); check("s3_before_3rd", 64'(rst3_sync_n), 64'd0);
    at(151); check("s3_released", 64'(rst3_sync_n), 64'd1);

    // Sub-cycle pulse 153-154. The output drops at once, and the full count
    // restarts with edges at 160, 170 and 180.
    at(153);
    q3.push_back('{153, 1'b0});
    rst3_async_n = 1'b0;
    at(154);
    q3.push_back('{180, 1'b1});
    rst3_async_n = 1'b1;
    at(171); check("s3_restart_pending", 64'(rst3_sync_n), 64'd0);
    at(181); check("s3_restart_done", 64'(rst3_sync_n), 64'd1);
    check("s2_still_held", 64'(rst2_sync_n), 64'd0);

    at(200);
    check("s2_queue_drained", 64'(q2.size()), 64'd0);
    check("s3_queue_drained", 64'(q3.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_reset_synchronizer
